block_sequencer: RTL and testbench
==================================

Name: block_sequencer

Overview:
- Walks every 8x8 block of a 320x240 YUV frame in raster order: Y plane first, then U, then V.
- Drives the sample counter / address generator stage with block column/row indices, plane base address and the Y/chroma stride select.
- Advances one block per downstream acknowledge.
- Sits directly upstream of the per-block sample address generator in the decode datapath.

Parameters:
- Y_COLS, 40, Y-plane blocks per row (320/8)
- Y_ROWS, 30, Y-plane block rows (240/8)
- C_COLS, 20, U/V-plane blocks per row (160/8)
- C_ROWS, 30, U/V-plane block rows
- Y_BASE, 18'd76800, Y-plane base address
- U_BASE, 18'd153600, U-plane base address
- V_BASE, 18'd192000, V-plane base address

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a frame when idle
- block_ack  in  1  single-cycle pulse from downstream; current block fully consumed
- block_req  out  1  high while a block is presented; indices valid
- colIdx  out  6  block column within current plane
- rowIdx  out  6  block row within current plane
- baseAddress  out  18  base address of current plane
- isYFinished  out  1  0 for Y plane (stride 320); 1 for U/V (stride 160)
- plane  out  2  0=Y, 1=U, 2=V
- blocks_done  out  12  acks accepted this frame (0..2400)
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  single-cycle pulse after the final V block is acknowledged

Behaviour:
- Reset (async, resetn low), all outputs 0:
  - state IDLE; block_req=0, colIdx=0, rowIdx=0, plane=0, baseAddress=Y_BASE, isYFinished=0, blocks_done=0, busy=0, done=0.
  - Reset mid-frame aborts immediately; no done pulse.
- States: IDLE, RUN_Y, RUN_U, RUN_V, FINISH.
- IDLE:
  - start=1 -> RUN_Y next cycle: block_req=1, col=0, row=0, plane=0, baseAddress=Y_BASE, blocks_done=0, busy=1.
  - block_ack ignored.
- RUN_*:
  - block_req held high continuously. Indices change only in the cycle after a block_ack.
  - On ack: blocks_done+1.
    - If col < COLS-1: col+1.
    - Else col=0; if row < ROWS-1: row+1.
    - Else plane transition: row=0, col=0.
  - COLS/ROWS: Y_COLS/Y_ROWS in RUN_Y; C_COLS/C_ROWS in RUN_U/RUN_V.
- Plane transitions, all registered and changing together with col/row:
  - RUN_Y -> RUN_U: baseAddress=U_BASE, plane=1, isYFinished=1.
  - RUN_U -> RUN_V: baseAddress=V_BASE, plane=2, isYFinished=1.
  - RUN_V last-block ack -> FINISH: block_req=0, done=1 for exactly one cycle, busy=0.
- FINISH -> IDLE unconditionally next cycle. Indices hold their last values until the next start.
- Outputs are registered; no combinational path from block_ack or start to any output.
- Simultaneous events:
  - start while busy is ignored.
  - start in the FINISH cycle is ignored.
  - block_ack with block_req=0 is ignored.
  - start and block_ack together in IDLE: start accepted, ack ignored.
- Ack latency: a back-to-back ack every cycle is legal. Each ack advances exactly one block with no dropped or duplicated indices.
- Width rules:
  - colIdx/rowIdx max 39/29 fit 6 bits.
  - blocks_done saturates at 2400 (Y 1200 + U 600 + V 600) and never wraps.
- Frame length: exactly Y_COLS*Y_ROWS + 2*C_COLS*C_ROWS acks.

Test Plan:
- Reset then start pulse -> next cycle block_req=1, col=0, row=0, plane=0, baseAddress=76800, isYFinished=0, busy=1.
- 39 acks on a fresh Y frame -> col=39, row=0. One more ack -> col=0, row=1, blocks_done=40.
- 1200 acks -> plane=1, baseAddress=153600, isYFinished=1, col=0, row=0. 600 further acks -> plane=2, baseAddress=192000.
- Full frame of 2400 acks issued every cycle -> done high exactly one cycle, after the 2400th ack. Then block_req=0, busy=0, blocks_done=2400. Extra acks cause no change.
- start pulsed mid-frame at blocks_done=500 -> indices unchanged, frame continues normally. Ack with block_req=0 in IDLE -> no change.
- resetn asserted at blocks_done=1300 (plane=1) -> all outputs 0 and baseAddress=76800 immediately. A new start restarts at col=0, row=0, plane=0.

Source files
------------

// File: rtl/block_sequencer.sv
// rtl/block_sequencer.sv - raster walk of 8x8 blocks over Y, U, V planes of a 320x240 frame
// Presents one block at a time to the sample address generator; one block_ack advances one block.
module block_sequencer #(
   parameter int          Y_COLS = 40,
   parameter int          Y_ROWS = 30,
   parameter int          C_COLS = 20,
   parameter int          C_ROWS = 30,
   parameter logic [17:0] Y_BASE = 18'd76800,
   parameter logic [17:0] U_BASE = 18'd153600,
   parameter logic [17:0] V_BASE = 18'd192000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        start,
   input  logic        block_ack,
   output logic        block_req,
   output logic [5:0]  colIdx,
   output logic [5:0]  rowIdx,
   output logic [17:0] baseAddress,
   output logic        isYFinished,
   output logic [1:0]  plane,
   output logic [11:0] blocks_done,
   output logic        busy,
   output logic        done
);

   localparam logic [5:0]  Y_COL_LAST = 6'(Y_COLS - 1);
   localparam logic [5:0]  Y_ROW_LAST = 6'(Y_ROWS - 1);
   localparam logic [5:0]  C_COL_LAST = 6'(C_COLS - 1);
   localparam logic [5:0]  C_ROW_LAST = 6'(C_ROWS - 1);
   localparam logic [11:0] TOTAL      = 12'(Y_COLS * Y_ROWS + 2 * C_COLS * C_ROWS);

   typedef enum logic [2:0] {IDLE, RUN_Y, RUN_U, RUN_V, FINISH} state_t;
   state_t state;

   logic last_col;
   logic last_row;

   always_comb begin
      last_col = 1'b0;
      last_row = 1'b0;
      if (state == RUN_Y) begin
         last_col = (colIdx == Y_COL_LAST);
         last_row = (rowIdx == Y_ROW_LAST);
      end else begin
         last_col = (colIdx == C_COL_LAST);
         last_row = (rowIdx == C_ROW_LAST);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         block_req   <= 1'b0;
         colIdx      <= '0;
         rowIdx      <= '0;
         baseAddress <= Y_BASE;
         isYFinished <= 1'b0;
         plane       <= 2'd0;
         blocks_done <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= RUN_Y;
                  block_req   <= 1'b1;
                  colIdx      <= '0;
                  rowIdx      <= '0;
                  baseAddress <= Y_BASE;
                  isYFinished <= 1'b0;
                  plane       <= 2'd0;
                  blocks_done <= '0;
                  busy        <= 1'b1;
               end
            end
            RUN_Y, RUN_U, RUN_V: begin
               if (block_ack) begin
                  if (blocks_done < TOTAL) begin
                     blocks_done <= blocks_done + 12'd1;
                  end
                  if (!last_col) begin
                     colIdx <= colIdx + 6'd1;
                  end else begin
                     colIdx <= '0;
                     if (!last_row) begin
                        rowIdx <= rowIdx + 6'd1;
                     end else begin
                        rowIdx <= '0;
                        case (state)
                           RUN_Y: begin
                              state       <= RUN_U;
                              baseAddress <= U_BASE;
                              plane       <= 2'd1;
                              isYFinished <= 1'b1;
                           end
                           RUN_U: begin
                              state       <= RUN_V;
                              baseAddress <= V_BASE;
                              plane       <= 2'd2;
                              isYFinished <= 1'b1;
                           end
                           default: begin
                              state     <= FINISH;
                              block_req <= 1'b0;
                              busy      <= 1'b0;
                              done      <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
            end
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_block_sequencer.sv
// tb/tb_block_sequencer.sv - vector-table bench for block_sequencer
// Each table row drives start/block_ack for a number of cycles, then checks every output.
module tb_block_sequencer;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        block_ack = 1'b0;
   logic        block_req;
   logic [5:0]  colIdx;
   logic [5:0]  rowIdx;
   logic [17:0] baseAddress;
   logic        isYFinished;
   logic [1:0]  plane;
   logic [11:0] blocks_done;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;
   int done_pulses = 0;

   block_sequencer dut (
      .clock(clock), .resetn(resetn), .start(start), .block_ack(block_ack),
      .block_req(block_req), .colIdx(colIdx), .rowIdx(rowIdx),
      .baseAddress(baseAddress), .isYFinished(isYFinished), .plane(plane),
      .blocks_done(blocks_done), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      if (done) done_pulses++;
   end

   typedef struct {
      logic s;
      logic a;
      int   reps;
      logic req;
      int   col;
      int   row;
      int   pl;
      int   base;
      logic isy;
      int   bd;
      logic bsy;
      logic dn;
   } vec_t;

   vec_t vec [14];

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic a);
      start     = s;
      block_ack = a;
      @(posedge clock);
      #1;
      start     = 1'b0;
      block_ack = 1'b0;
   endtask

   task automatic check_all(input string tag, input vec_t v);
      cmp({tag, ".block_req"}, int'(block_req), int'(v.req));
      cmp({tag, ".colIdx"}, int'(colIdx), v.col);
      cmp({tag, ".rowIdx"}, int'(rowIdx), v.row);
      cmp({tag, ".plane"}, int'(plane), v.pl);
      cmp({tag, ".baseAddress"}, int'(baseAddress), v.base);
      cmp({tag, ".isYFinished"}, int'(isYFinished), int'(v.isy));
      cmp({tag, ".blocks_done"}, int'(blocks_done), v.bd);
      cmp({tag, ".busy"}, int'(busy), int'(v.bsy));
      cmp({tag, ".done"}, int'(done), int'(v.dn));
   endtask

   initial begin
      vec_t rst_v;
      //        s  a  reps req col row pl base    isy bd    busy done
      vec[0]  = '{1, 1, 1,   1, 0,  0,  0, 76800,  0, 0,    1, 0}; // start+ack in IDLE: ack ignored
      vec[1]  = '{0, 1, 39,  1, 39, 0,  0, 76800,  0, 39,   1, 0};
      vec[2]  = '{0, 1, 1,   1, 0,  1,  0, 76800,  0, 40,   1, 0};
      vec[3]  = '{0, 0, 3,   1, 0,  1,  0, 76800,  0, 40,   1, 0};
      vec[4]  = '{0, 1, 460, 1, 20, 12, 0, 76800,  0, 500,  1, 0};
      vec[5]  = '{1, 0, 1,   1, 20, 12, 0, 76800,  0, 500,  1, 0}; // start while busy
      vec[6]  = '{1, 1, 1,   1, 21, 12, 0, 76800,  0, 501,  1, 0};
      vec[7]  = '{0, 1, 699, 1, 0,  0,  1, 153600, 1, 1200, 1, 0};
      vec[8]  = '{0, 1, 1,   1, 1,  0,  1, 153600, 1, 1201, 1, 0};
      vec[9]  = '{0, 1, 599, 1, 0,  0,  2, 192000, 1, 1800, 1, 0};
      vec[10] = '{0, 1, 599, 1, 19, 29, 2, 192000, 1, 2399, 1, 0};
      vec[11] = '{0, 1, 1,   0, 0,  0,  2, 192000, 1, 2400, 0, 1}; // final ack -> FINISH
      vec[12] = '{1, 1, 1,   0, 0,  0,  2, 192000, 1, 2400, 0, 0}; // start in FINISH ignored
      vec[13] = '{0, 1, 5,   0, 0,  0,  2, 192000, 1, 2400, 0, 0}; // ack in IDLE ignored

      rst_v = '{0, 0, 0, 0, 0, 0, 0, 76800, 0, 0, 0, 0};

      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_all("reset", rst_v);
      resetn = 1'b1;
      step(1'b0, 1'b1);
      check_all("idle_ack", rst_v);

      for (int i = 0; i < 14; i++) begin
         for (int r = 0; r < vec[i].reps; r++) step(vec[i].s, vec[i].a);
         check_all($sformatf("vec%0d", i), vec[i]);
      end
      cmp("done_pulses_frame", done_pulses, 1);

      // Second frame, aborted by asynchronous reset in the middle of the U plane.
      step(1'b1, 1'b0);
      for (int r = 0; r < 1300; r++) step(1'b0, 1'b1);
      cmp("mid.plane", int'(plane), 1);
      cmp("mid.col", int'(colIdx), 0);
      cmp("mid.row", int'(rowIdx), 5);
      cmp("mid.blocks_done", int'(blocks_done), 1300);
      #3;
      resetn = 1'b0;
      #1;
      check_all("async_reset", rst_v);
      @(posedge clock);
      #1;
      resetn = 1'b1;
      step(1'b1, 1'b0);
      check_all("restart", vec[0]);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      cmp("restart.col2", int'(colIdx), 2);
      cmp("restart.bd2", int'(blocks_done), 2);
      cmp("done_pulses_total", done_pulses, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
